// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter BHT plus direct-mapped BTB, resolved in EX.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into the BHT index.
module branch_predictor #(
  parameter int ENTRIES = 64,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [31:0]   pc_f_i,
  output logic          pred_taken_f_o,
  output logic [31:0]   pred_pc_f_o,
  output logic [IW-1:0] bht_idx_f_o,
  input  logic          valid_ex_i,
  input  logic          stall_ex_i,
  input  logic          br_ex_i,
  input  logic          taken_ex_i,
  input  logic [31:0]   target_ex_i,
  input  logic [31:0]   pc_ex_i,
  input  logic          pred_taken_ex_i,
  input  logic [31:0]   pred_pc_ex_i,
  input  logic [IW-1:0] bht_idx_ex_i,
  output logic [1:0]    PC_taken_o,
  output logic [31:0]   redirect_pc_o
);

  localparam int TW = 30 - IW;

  logic [1:0]         bht_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IW-1:0] pc_idx_f, pc_idx_ex, bht_idx_f;
  logic          btb_hit_f, resolve, br_taken, mis_taken, mis_fall;
  logic [31:0]   pc_f_plus4, pc_ex_plus4;

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign pc_idx_f    = pc_f_i[IW+1:2];
  assign pc_idx_ex   = pc_ex_i[IW+1:2];
  assign pc_f_plus4  = pc_f_i + 32'd4;
  assign pc_ex_plus4 = pc_ex_i + 32'd4;

`ifdef BP_GSHARE_EN
  logic [IW-1:0] ghr_q, ghr_d;

  assign bht_idx_f = pc_idx_f ^ ghr_q;
  assign ghr_d     = (resolve && br_ex_i) ? {ghr_q[IW-2:0], taken_ex_i} : ghr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ghr_q <= '0;
    else         ghr_q <= ghr_d;
  end
`else
  assign bht_idx_f = pc_idx_f;
`endif

  // IF lookup
  assign btb_hit_f      = valid_q[pc_idx_f] && (tag_q[pc_idx_f] == pc_f_i[31:IW+2]);
  assign pred_taken_f_o = rst_ni && bht_q[bht_idx_f][1] && btb_hit_f;
  assign pred_pc_f_o    = pred_taken_f_o ? tgt_q[pc_idx_f] : pc_f_plus4;
  assign bht_idx_f_o    = bht_idx_f;

  // EX resolve; a stalled instruction only resolves once the stall drops
  assign resolve   = rst_ni && valid_ex_i && !stall_ex_i;
  assign br_taken  = br_ex_i && taken_ex_i;
  assign mis_taken = resolve && br_taken && (!pred_taken_ex_i || (pred_pc_ex_i != target_ex_i));
  assign mis_fall  = resolve && pred_taken_ex_i && !br_taken;

  always_comb begin
    PC_taken_o    = 2'b00;
    redirect_pc_o = pc_ex_plus4;
    if (mis_taken) begin
      PC_taken_o    = 2'b01;
      redirect_pc_o = target_ex_i;
    end else if (mis_fall) begin
      PC_taken_o    = 2'b10;
    end
  end

  // Counters and valid bits reset; tag/target storage does not need to
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
      valid_q <= '0;
    end else if (resolve) begin
      if (br_ex_i) bht_q[bht_idx_ex_i] <= sat_cnt(bht_q[bht_idx_ex_i], taken_ex_i);
      if (br_taken) valid_q[pc_idx_ex] <= 1'b1;
      else if (!br_ex_i && pred_taken_ex_i) valid_q[pc_idx_ex] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (resolve && br_taken) begin
      tag_q[pc_idx_ex] <= pc_ex_i[31:IW+2];
      tgt_q[pc_idx_ex] <= target_ex_i;
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor that sits upstream of the hazard unit. It predicts the next fetch PC in IF using a 2-bit-counter BHT and a direct-mapped BTB. It resolves predictions in EX and drives the 2-bit `PC_taken_o` mispredict code that the hazard unit turns into `Flush_ID` and `Flush_EX`. It also provides the redirect PC to the PC mux.

## Interface
- `ENTRIES`, default 64: BHT and BTB depth; power of two, ≥4. `IW = log2(ENTRIES)`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; one clock, synchronous, active-low.
- `pc_f_i`  in  32  fetch-stage PC.
- `pred_taken_f_o`  out  1  predict taken for `pc_f_i`.
- `pred_pc_f_o`  out  32  predicted next PC: the BTB target if taken, else `pc_f_i+4`.
- `bht_idx_f_o`  out  IW  BHT index used for this prediction; the pipeline carries it to EX.
- `valid_ex_i`  in  1  EX holds a real instruction, not a bubble.
- `stall_ex_i`  in  1  EX held this cycle (hazard `Stall_EX`).
- `br_ex_i`  in  1  EX instruction is a branch/jal/jalr.
- `taken_ex_i`  in  1  resolved direction.
- `target_ex_i`  in  32  resolved target.
- `pc_ex_i`  in  32  EX PC.
- `pred_taken_ex_i`, `pred_pc_ex_i`, `bht_idx_ex_i`  in  1/32/IW  prediction carried from IF.
- `PC_taken_o`  out  2  00 correct; 01 redirect to the taken target; 10 redirect to fall-through.
- `redirect_pc_o`  out  32  PC to fetch when `PC_taken_o != 00`.

## Operation
- **State**
  - BHT: `ENTRIES` × 2-bit saturating counters. 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T.
  - BTB: `ENTRIES` × {valid, tag = PC[31:IW+2], target[31:0]}, indexed by PC[IW+1:2].
- **Lookup (combinational, IF)**
  - `pred_taken_f_o = BHT[idx][1] & BTB.valid & (BTB.tag == pc_f_i tag)`.
  - The BHT index is PC[IW+1:2], or the gshare index when that feature is configured in.
- **Resolve (combinational, EX)**: active only when `resolve = valid_ex_i & ~stall_ex_i`; otherwise `PC_taken_o = 00`.
  - `br_ex_i & taken_ex_i & (~pred_taken_ex_i | pred_pc_ex_i != target_ex_i)` → 01, `redirect_pc_o = target_ex_i`.
  - `pred_taken_ex_i & ~(br_ex_i & taken_ex_i)` → 10, `redirect_pc_o = pc_ex_i+4`. This covers both a branch that was not taken and BTB aliasing onto a non-branch.
  - Otherwise → 00, and `redirect_pc_o = pc_ex_i+4` (don't-care).
- **Update (clock edge, when `resolve`)**
  - If `br_ex_i`: BHT[`bht_idx_ex_i`] increments if taken, decrements if not; saturates at 11 and 00.
  - If `br_ex_i & taken_ex_i`: write the BTB entry {1, tag, `target_ex_i`}.
  - If `~br_ex_i & pred_taken_ex_i`: clear that BTB entry's valid bit.
  - A not-taken branch leaves the BTB unchanged.
- **Reset**
  - While `rst_ni` = 0: `pred_taken_f_o` = 0, `pred_pc_f_o = pc_f_i+4`, `PC_taken_o` = 00, `redirect_pc_o = pc_ex_i+4`.
  - At the edge: all BHT counters ← 01, all BTB valid bits ← 0, GHR ← 0.
  - Reset asserted mid-operation discards any update pending that cycle.

## Timing
- Prediction: zero-cycle combinational path from `pc_f_i`.
- `PC_taken_o` and `redirect_pc_o`: combinational in the same cycle the branch is in EX. The hazard unit flushes ID/EX that cycle, and the PC loads `redirect_pc_o` at the next edge. Mispredict penalty is 2 cycles.
- Table writes occur at the edge that ends the resolve cycle and are visible to lookups from the next cycle on.
- A same-cycle lookup and update of the same entry returns the OLD contents (read-before-write).
- A stalled EX instruction resolves exactly once, in the cycle the stall drops, so there is no double update.

## Configuration
- **`BP_GSHARE_EN` defined**
  - IW-bit global history register (GHR), reset to 0.
  - BHT index = PC[IW+1:2] XOR GHR.
  - On each resolved branch: `GHR ← {GHR[IW-2:0], taken_ex_i}`. The GHR is non-speculative.
  - The BHT is updated at `bht_idx_ex_i`, the index captured at fetch.
- **`BP_GSHARE_EN` undefined**: no GHR; BHT index = PC[IW+1:2]; `bht_idx_f_o` equals those PC bits.
- The BTB is PC-indexed in both builds.

## Test plan
- **Reset state**: reset, then `pc_f_i=0x100` → `pred_taken_f_o=0`, `pred_pc_f_o=0x104`; `valid_ex_i=0` → `PC_taken_o=00`.
- **Cold taken branch**: branch at 0x100 to 0x200, taken, `pred_taken_ex_i=0` → `PC_taken_o=01`, `redirect_pc_o=0x200`. Next cycle, `pc_f_i=0x100` → `pred_taken_f_o=1` (counter 10), `pred_pc_f_o=0x200`.
- **Predicted taken, falls through**: predicted taken at 0x100, resolves not taken → `PC_taken_o=10`, `redirect_pc_o=0x104`. Counter 10→01; the next lookup predicts not taken.
- **Saturation**: four taken resolves then one not-taken at 0x100 → counter 11 then 10; still predicts taken, `pred_pc_f_o=0x200`.
- **Stall and aliasing**: `stall_ex_i=1` for 3 cycles with a taken branch in EX → `PC_taken_o=00` and no table change until the stall drops, then exactly one update. A non-branch at 0x100 arriving with `pred_taken_ex_i=1` → `PC_taken_o=10`, `redirect_pc_o=0x104`, and BTB[0x100] is invalidated.
- **Gshare index (`BP_GSHARE_EN`, `ENTRIES=64`)**: after resolving taken, not-taken, taken (GHR=000101), `pc_f_i=0x100` → `bht_idx_f_o = 0x00 ^ 0x05 = 0x05`.
